// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the MIPS datapath blocks.
//   dmem_state_t    - data-memory bridge FSM states
//   WORD_ALIGN_MASK - value ALUOut[1:0] must have for a word access
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } dmem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/watchdog_counter.sv
// watchdog_counter: bounds the time a bridge transaction may stay in flight.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : force the count to zero (bridge idle)
//   enable   : count this cycle (transaction in flight)
//   expired  : this enabled cycle is the last one allowed; the count reaches
//              TIMEOUT_CYCLES-1 on the coming edge
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Cycles in flight are numbered 0..TIMEOUT_CYCLES-2, so the bridge spends
  // at most TIMEOUT_CYCLES-1 cycles in REQ+RESP.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the single-cycle MIPS datapath's data-memory port to
// a handshaked memory bus, one bus transaction per load/store.
//   ALUOut/WriteData/MemRead/MemWrite : access from the core
//   ReadData   : load data for the MemtoReg mux (non-zero only in DONE)
//   Stall      : core holds PC and suppresses RegWrite
//   Misaligned : sticky, an access had ALUOut[1:0] != 0
//   BusErr     : sticky, a transaction timed out
//   bus_req_*  : request channel; bus_rsp_* : response channel
//   state_dbg  : current FSM state for observation
//
// Handshake: a request transfers on a cycle where bus_req_valid and
// bus_req_ready are both high; addr/we/wdata are registered and held while
// valid is high. The memory returns exactly one bus_rsp_valid pulse per
// accepted request; pulses arriving outside RESP are ignored.
module dmem_bridge
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ALUOut,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Misaligned,
  output logic                  BusErr,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_we,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  input  logic                  bus_rsp_valid,
  input  logic [DATA_WIDTH-1:0] bus_rsp_rdata,
  output logic [1:0]            state_dbg
);

  dmem_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] read_buf;
  logic                  access, aligned, start, expired, in_flight, completed, timeout_hit;

  assign access    = MemRead | MemWrite;
  assign aligned   = (ALUOut[1:0] == WORD_ALIGN_MASK);
  assign start     = (state == IDLE) && access && aligned;
  assign in_flight = (state == REQ) || (state == RESP);
  assign completed = (state == RESP) && bus_rsp_valid;
  // A response arriving on the last allowed cycle still completes normally.
  assign timeout_hit = expired && !completed;

  watchdog_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (in_flight),
    .expired (expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      // On the last allowed cycle the abort wins over a late acceptance.
      REQ:  if (expired) state_nxt = DONE;
            else if (bus_req_ready) state_nxt = RESP;
      RESP: if (bus_rsp_valid || expired) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request registers only load when a transaction starts, so they stay
  // stable for the whole REQ phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_we    <= 1'b0;
    end else if (start) begin
      bus_req_addr  <= {ALUOut[ADDR_WIDTH-1:2], 2'b00};
      bus_req_wdata <= WriteData;
      bus_req_we    <= MemWrite;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_buf <= '0;
    end else if (completed && !bus_req_we) begin
      read_buf <= bus_rsp_rdata;
    end else if (timeout_hit) begin
      read_buf <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Misaligned <= 1'b0;
      BusErr     <= 1'b0;
    end else begin
      if ((state == IDLE) && access && !aligned) Misaligned <= 1'b1;
      if (timeout_hit) BusErr <= 1'b1;
    end
  end

  // Derived from the asynchronously reset state, so valid and the in-flight
  // stall terms drop as soon as rst asserts.
  assign bus_req_valid = (state == REQ);
  assign Stall         = start || in_flight;
  assign ReadData      = (state == DONE) ? read_buf : '0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

  localparam int TOUT = 8;

  logic        clk, rst;
  logic [31:0] ALUOut, WriteData, ReadData;
  logic        MemRead, MemWrite, Stall, Misaligned, BusErr;
  logic        bus_req_valid, bus_req_ready, bus_req_we, bus_rsp_valid;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  // Reference model: word memory seen by the bus, last loaded word, sticky flags.
  logic [31:0] mem [logic [29:0]];
  logic [31:0] last_read = 0;
  bit          mis_flag  = 0;
  bit          err_flag  = 0;
  logic [31:0] exp_q[$];

  dmem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .rst(rst), .ALUOut(ALUOut), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
    .Misaligned(Misaligned), .BusErr(BusErr), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rsp_rdata(bus_rsp_rdata), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 0;
  always #5 clk = ~clk;

  task automatic drive_idle_inputs();
    MemRead = 0; MemWrite = 0; ALUOut = 0; WriteData = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One aligned access with the bench acting as memory: ready after req_wait
  // cycles of valid, response rsp_wait cycles after acceptance.
  task automatic do_access(input logic mr, input logic mw, input logic [31:0] addr,
                           input logic [31:0] wdata, input int req_wait, input int rsp_wait);
    logic [29:0] w;
    logic [31:0] exp_rd;
    int  busy_exp, valid_exp, stall_n, valid_n, rw, sw;
    bit  timed_out, accepted, done, hold_ok, rd_zero_ok;
    w  = addr[31:2];
    rw = req_wait;
    sw = rsp_wait;
    if (!mem.exists(w)) mem[w] = $urandom;
    busy_exp  = (req_wait + 1) + (rsp_wait + 1);
    valid_exp = (req_wait + 1 < TOUT - 1) ? req_wait + 1 : TOUT - 1;
    timed_out = busy_exp > TOUT - 1;
    if (timed_out) begin
      busy_exp = TOUT - 1; exp_rd = 0; last_read = 0; err_flag = 1;
    end else if (mw) begin
      exp_rd = last_read;
    end else begin
      exp_rd = mem[w]; last_read = exp_rd;
    end
    exp_q.push_back(exp_rd);

    @(negedge clk);
    MemRead = mr; MemWrite = mw; ALUOut = addr; WriteData = wdata;
    bus_req_ready = 0; bus_rsp_valid = 0;
    #1;
    tests++;
    if (Stall !== 1'b1) begin
      fails++; $display("FAIL idle_stall: got %0b expected 1", Stall);
    end
    stall_n = 1; valid_n = 0; accepted = 0; done = 0; hold_ok = 1; rd_zero_ok = 1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = $urandom;
      if (bus_req_valid) begin
        valid_n++;
        if (bus_req_addr !== {addr[31:2], 2'b00} || bus_req_we !== mw ||
            bus_req_wdata !== wdata) hold_ok = 0;
        if (rw == 0) begin
          bus_req_ready = 1; accepted = 1;
          if (mw) mem[w] = wdata;
        end else rw--;
      end else if (accepted && Stall) begin
        if (sw == 0) begin
          bus_rsp_valid = 1;
          bus_rsp_rdata = mw ? $urandom : mem[w];
        end else sw--;
      end
      #1;
      if (Stall) begin
        stall_n++;
        if (ReadData !== 0) rd_zero_ok = 0;
      end else done = 1;
    end
    tests++;
    if (!done) begin
      fails++; $display("FAIL done_wait: DONE not reached within 64 cycles");
    end
    bus_req_ready = 0; bus_rsp_valid = 0;
    check("stall_cycles", stall_n, 1 + busy_exp);
    check("valid_cycles", valid_n, valid_exp);
    check("req_hold", {31'd0, hold_ok}, 1);
    check("rdata_zero_stalled", {31'd0, rd_zero_ok}, 1);
    check("read_data", ReadData, exp_q.pop_front());
    check("bus_err", {31'd0, BusErr}, {31'd0, err_flag});
    check("misaligned_flag", {31'd0, Misaligned}, {31'd0, mis_flag});
  endtask

  task automatic misaligned_op(input logic mr, input logic mw, input logic [31:0] addr);
    @(negedge clk);
    MemRead = mr; MemWrite = mw; ALUOut = addr; WriteData = $urandom;
    bus_req_ready = 0; bus_rsp_valid = 0;
    #1;
    check("mis_stall", {31'd0, Stall}, 0);
    check("mis_rdata", ReadData, 0);
    check("mis_valid", {31'd0, bus_req_valid}, 0);
    mis_flag = 1;
    @(negedge clk);
    MemRead = 0; MemWrite = 0;
    #1;
    check("mis_sticky", {31'd0, Misaligned}, 1);
    check("mis_no_req", {31'd0, bus_req_valid}, 0);
  endtask

  task automatic nop_op();
    @(negedge clk);
    MemRead = 0; MemWrite = 0; ALUOut = $urandom; WriteData = $urandom;
    #1;
    check("nop_stall", {31'd0, Stall}, 0);
    check("nop_valid", {31'd0, bus_req_valid}, 0);
    check("nop_rdata", ReadData, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0;
    drive_idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("rst_rdata", ReadData, 0);
    check("rst_stall", {31'd0, Stall}, 0);
    check("rst_mis", {31'd0, Misaligned}, 0);
    check("rst_err", {31'd0, BusErr}, 0);
    check("rst_valid", {31'd0, bus_req_valid}, 0);
    check("rst_we", {31'd0, bus_req_we}, 0);
    check("rst_addr", bus_req_addr, 0);
    check("rst_wdata", bus_req_wdata, 0);
  endtask

  task automatic test_aligned_load();
    mem[30'h4] = 32'hDEAD_BEEF;
    do_access(1, 0, 32'h0000_0010, 32'h0, 0, 0);
  endtask

  task automatic test_store_backpressure();
    do_access(0, 1, 32'h0000_0020, 32'h1234_5678, 4, 0);
    do_access(1, 0, 32'h0000_0020, 32'h0, 0, 1);
  endtask

  task automatic test_misaligned();
    misaligned_op(1, 0, 32'h0000_0013);
    nop_op();
    check("mis_still_set", {31'd0, Misaligned}, 1);
  endtask

  task automatic test_timeout();
    do_access(1, 0, 32'h0000_0040, 32'h0, 100, 0);
    nop_op();
    check("err_sticky", {31'd0, BusErr}, 1);
  endtask

  task automatic test_read_write();
    do_access(1, 0, 32'h0000_0044, 32'h0, 0, 0);
    do_access(1, 1, 32'h0000_0048, 32'hCAFE_F00D, 1, 1);
  endtask

  task automatic test_back_to_back();
    do_access(0, 1, 32'h0000_0080, 32'hA5A5_0001, 0, 0);
    do_access(1, 0, 32'h0000_0080, 32'h0, 0, 0);
    do_access(1, 0, 32'h0000_0084, 32'h0, 2, 2);
  endtask

  task automatic test_reset_mid_resp();
    @(negedge clk);
    MemRead = 1; MemWrite = 0; ALUOut = 32'h0000_0100;
    @(negedge clk);
    bus_req_ready = 1;
    @(negedge clk);
    bus_req_ready = 0;
    check("pre_rst_stall", {31'd0, Stall}, 1);
    MemRead = 0;
    #2 rst = 0;
    #1;
    check("rst_async_valid", {31'd0, bus_req_valid}, 0);
    check("rst_async_stall", {31'd0, Stall}, 0);
    @(negedge clk);
    rst = 1;
    mis_flag = 0; err_flag = 0; last_read = 0;
    #1;
    check("post_rst_mis", {31'd0, Misaligned}, 0);
    check("post_rst_err", {31'd0, BusErr}, 0);
    check("post_rst_rdata", ReadData, 0);
    @(negedge clk);
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h5555_AAAA;
    #1;
    check("stray_rsp_stall", {31'd0, Stall}, 0);
    @(negedge clk);
    bus_rsp_valid = 0;
    #1;
    check("stray_rsp_rdata", ReadData, 0);
    check("stray_rsp_valid", {31'd0, bus_req_valid}, 0);
    do_access(1, 0, 32'h0000_0104, 32'h0, 0, 0);
  endtask

  task automatic test_random();
    int kind, rq, sp;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, 63)) << 2;
      rq   = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 2);
      sp   = $urandom_range(0, 2);
      case (kind)
        0:       nop_op();
        1:       misaligned_op(1'($urandom_range(0, 1)), 1,
                               addr | 32'($urandom_range(1, 3)));
        2, 3, 9: do_access(1, 0, addr, 32'h0, rq, sp);
        4, 5, 6: do_access(0, 1, addr, $urandom, rq, sp);
        default: do_access(1, 1, addr, $urandom, rq, sp);
      endcase
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_aligned_load();
    test_store_backpressure();
    test_misaligned();
    test_read_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_resp();
    test_random();
    @(negedge clk);
    drive_idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle MIPS datapath and an external handshaked memory bus. It takes the load/store address (ALUOut), store data (WriteData) and the MemRead/MemWrite strobes from the core. It runs one bus transaction per access and returns ReadData to the datapath's MemtoReg mux. While a transaction is in flight it asserts Stall, and the core must hold PC and suppress RegWrite.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width (matches ALUOut).
- DATA_WIDTH, 32, word width (matches WriteData/ReadData).
- TIMEOUT_CYCLES, 256, maximum cycles spent in REQ+RESP before abort; must be ≥ 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ALUOut  in  ADDR_WIDTH  access byte address.
- WriteData  in  DATA_WIDTH  store data.
- MemRead  in  1  load request.
- MemWrite  in  1  store request.
- ReadData  out  DATA_WIDTH  load data to datapath.
- Stall  out  1  core must freeze PC and register-file write.
- Misaligned  out  1  sticky: an access had ALUOut[1:0] != 0.
- BusErr  out  1  sticky: a transaction timed out.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  memory accepts request.
- bus_req_we  out  1  1 = write.
- bus_req_addr  out  ADDR_WIDTH  registered word-aligned address.
- bus_req_wdata  out  DATA_WIDTH  registered store data.
- bus_rsp_valid  in  1  response/ack valid (one cycle per request).
- bus_rsp_rdata  in  DATA_WIDTH  read data, valid with bus_rsp_valid.

## Operation
- States: IDLE, REQ, RESP, DONE.
- access = MemRead | MemWrite. If both are high, the access is a write.
- IDLE, aligned access:
  - latch address, wdata and we; go to REQ.
  - Stall = 1 combinationally in this cycle.
- IDLE, misaligned access (ALUOut[1:0] != 0):
  - no bus transaction, Stall = 0, ReadData = 0.
  - Misaligned sets on the next edge; state stays IDLE.
- REQ: bus_req_valid = 1. On bus_req_ready go to RESP.
- RESP: wait for bus_rsp_valid.
  - On a read, capture bus_rsp_rdata into read_buf; on a write, leave read_buf unchanged.
  - Go to DONE.
- DONE: Stall = 0 for exactly one cycle; go to IDLE. The core commits on this edge.
- Stall = (IDLE & access & aligned) | REQ | RESP.
- ReadData = read_buf in DONE, otherwise 0.
- bus_rsp_valid outside RESP is ignored.
- Timeout:
  - Counter clears in IDLE and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion, go to DONE with read_buf = 0 and set BusErr.
  - bus_req_valid drops in that same transition.
- Misaligned and BusErr clear only on reset.

## Timing
- Reset values:
  - state IDLE.
  - Outputs: ReadData, Stall (aside from the combinational IDLE term), Misaligned, BusErr, bus_req_valid and bus_req_we = 0.
  - bus_req_addr, bus_req_wdata, read_buf = 0.
- Reset mid-transaction: bus_req_valid deasserts asynchronously, the outstanding response is discarded, and the bridge returns to IDLE.
- Minimum latency is 3 stall cycles plus 1 DONE cycle, so a memory instruction takes 4 cycles. This assumes bus_req_ready is high in REQ and bus_rsp_valid arrives the cycle after acceptance.
- Non-memory instructions: zero added latency, Stall = 0.
- While bus_req_valid is high, bus_req_addr, bus_req_we and bus_req_wdata are stable until the cycle after bus_req_ready.
- Back-to-back accesses: an access in the cycle after DONE starts a new transaction from IDLE; no cycle is lost beyond DONE.

## Structure
- Shared package mips_pkg holds:
  - the dmem_state_t enum (IDLE, REQ, RESP, DONE);
  - the alignment mask constant WORD_ALIGN_MASK = 2'b00.
- Sub-module watchdog_counter holds the timeout logic.
  - Parameter: TIMEOUT_CYCLES.
  - Ports: clk, rst, clear, enable, expired.
- The FSM, request registers and read_buf live in dmem_bridge.

## Test plan
- Aligned load:
  - ALUOut=0x0000_0010, MemRead=1; memory accepts immediately and responds 0xDEAD_BEEF one cycle later.
  - Required: Stall high for 3 cycles; ReadData=0xDEAD_BEEF in DONE; bus_req_we=0.
- Store with backpressure:
  - MemWrite=1, ALUOut=0x20, WriteData=0x1234_5678, bus_req_ready low for 4 cycles.
  - Required: addr and wdata stable throughout; Stall=1 until the ack; DONE follows the ack.
- Misaligned:
  - MemRead=1, ALUOut=0x13.
  - Required: no bus_req_valid; Stall=0; ReadData=0; Misaligned=1 next cycle and stays set.
- Timeout:
  - TIMEOUT_CYCLES=8, bus_req_ready never asserted.
  - Required: bus_req_valid for 7 cycles, then DONE with ReadData=0; BusErr=1 sticky.
- Reset mid-RESP:
  - Drive rst=0 asynchronously between clock edges while in RESP.
  - Required: bus_req_valid and Stall drop immediately. After release: IDLE, all outputs 0, and a later bus_rsp_valid is ignored.
- Simultaneous read and write:
  - MemRead=MemWrite=1.
  - Required: bus_req_we=1, and read_buf unchanged after the ack.
